// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary encoder using reverse double-dabble.
// Each step shifts {bcd, bin} right and subtracts 3 from any BCD digit that is 8 or more.
module bcd_to_bin_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_reg;
  logic [BIN_W-1:0] bin_shift;
  logic [CNT_W-1:0] step_cnt;
  logic             digit_err;
  logic             accept;
  logic             last_step;

  // One conversion step: the shift carries the BCD LSB into the binary MSB,
  // then each digit is corrected independently.
  always_comb begin
    {bcd_shift, bin_shift} = {bcd_reg, bin_reg} >> 1;
    bcd_adj = bcd_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_shift[4*d +: 4] >= 4'd8) begin
        bcd_adj[4*d +: 4] = bcd_shift[4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    digit_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        digit_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (!digit_err) begin
            state_next = CONV;
          end
        end
      end
      CONV: begin
        if (step_cnt == CNT_W'(BIN_W - 1)) begin
          last_step  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A rejected request never touches the shift registers; bin_out only
  // changes at completion or on a rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg  <= '0;
      bin_reg  <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bin_out  <= '0;
    end else begin
      done <= 1'b0;
      if (accept && digit_err) begin
        err     <= 1'b1;
        done    <= 1'b1;
        bin_out <= '0;
      end else if (accept) begin
        bcd_reg  <= bcd_in;
        bin_reg  <= '0;
        step_cnt <= '0;
        busy     <= 1'b1;
        err      <= 1'b0;
      end else if (state == CONV) begin
        bcd_reg  <= bcd_adj;
        bin_reg  <= bin_shift;
        step_cnt <= step_cnt + CNT_W'(1);
        if (last_step) begin
          bin_out <= bin_shift;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: 2-digit and 3-digit instances checked against a
// decimal-arithmetic reference model with directed and random requests.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start2;
  logic [7:0] bcd_in2;
  logic       busy2, done2, err2;
  logic [6:0] bin2;
  logic        start3;
  logic [11:0] bcd_in3;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int tests_run    = 0;
  int tests_failed = 0;
  int last_bin2    = 0;
  int last_err2    = 0;

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bcd_in(bcd_in2),
    .busy(busy2), .done(done2), .err(err2), .bin_out(bin2)
  );

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd_in3),
    .busy(busy3), .done(done3), .err(err3), .bin_out(bin3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: weight each digit by its decimal position; any digit over 9 is an error.
  function automatic int bcdModel(input logic [15:0] bcd, input int digits, output bit bad);
    int value;
    int dig;
    logic [15:0] tmp;
    value = 0;
    bad   = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      tmp = bcd >> (4 * i);
      dig = int'(tmp[3:0]);
      if (dig > 9) bad = 1'b1;
      value = value * 10 + dig;
    end
    return bad ? 0 : value;
  endfunction

  // Starts on the current negedge, so calling it right after a done gives back-to-back.
  task automatic applyStimulus(input logic [7:0] bcd, input int poke_step, input bit noise);
    int exp_val, wait_cycles, busy_cycles;
    bit exp_err;
    exp_val = bcdModel({8'h00, bcd}, 2, exp_err);
    bcd_in2 = bcd;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    if (exp_err) begin
      checkOutput("errDone", int'(done2), 1);
      checkOutput("errFlag", int'(err2), 1);
      checkOutput("errBin", int'(bin2), 0);
      checkOutput("errBusy", int'(busy2), 0);
      last_bin2 = 0;
      last_err2 = 1;
    end else begin
      wait_cycles = 0;
      busy_cycles = 0;
      while (!done2 && wait_cycles < 40) begin
        if (busy2) busy_cycles++;
        if (wait_cycles == poke_step) begin
          start2  = 1'b1;
          bcd_in2 = 8'h11;
        end else if (noise && $urandom_range(0, 2) == 0) begin
          start2  = 1'b1;
          bcd_in2 = 8'($urandom);
        end else begin
          start2 = 1'b0;
        end
        @(negedge clk);
        wait_cycles++;
      end
      start2 = 1'b0;
      checkOutput("doneLatency", wait_cycles, 7);
      checkOutput("busyCycles", busy_cycles, 7);
      checkOutput("binOut", int'(bin2), exp_val);
      checkOutput("errClear", int'(err2), 0);
      checkOutput("busyAtDone", int'(busy2), 0);
      last_bin2 = exp_val;
      last_err2 = 0;
    end
  endtask

  task automatic holdCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("holdDone", int'(done2), 0);
      checkOutput("holdBusy", int'(busy2), 0);
      checkOutput("holdBin", int'(bin2), last_bin2);
      checkOutput("holdErr", int'(err2), last_err2);
    end
  endtask

  task automatic applyStimulusWide(input logic [11:0] bcd);
    int exp_val, wait_cycles, busy_cycles;
    bit exp_err;
    exp_val = bcdModel({4'h0, bcd}, 3, exp_err);
    bcd_in3 = bcd;
    start3  = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_cycles = 0;
    busy_cycles = 0;
    while (!done3 && wait_cycles < 40) begin
      if (busy3) busy_cycles++;
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput("wideLatency", wait_cycles, exp_err ? 0 : 10);
    checkOutput("wideBusy", busy_cycles, exp_err ? 0 : 10);
    checkOutput("wideBin", int'(bin3), exp_val);
    checkOutput("wideErr", int'(err3), int'(exp_err));
    @(negedge clk);
    checkOutput("widePulse", int'(done3), 0);
  endtask

  initial begin
    logic [7:0] rnd;
    rst     = 1'b1;
    start2  = 1'b0;
    bcd_in2 = '0;
    start3  = 1'b0;
    bcd_in3 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", int'(busy2), 0);
    checkOutput("rstDone", int'(done2), 0);
    checkOutput("rstErr", int'(err2), 0);
    checkOutput("rstBin", int'(bin2), 0);
    checkOutput("rstBinWide", int'(bin3), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'h42, -1, 1'b0);
    holdCheck(2);
    applyStimulus(8'h99, -1, 1'b0);
    applyStimulus(8'h00, -1, 1'b0);
    holdCheck(1);
    applyStimulus(8'h1A, -1, 1'b0);
    holdCheck(2);
    applyStimulus(8'h07, -1, 1'b0);
    holdCheck(1);
    applyStimulus(8'h55, 3, 1'b0);
    holdCheck(3);

    // Abort mid-conversion: reset lands on step-4 edge.
    bcd_in2 = 8'h63;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", int'(busy2), 0);
    checkOutput("abortBin", int'(bin2), 0);
    last_bin2 = 0;
    last_err2 = 0;
    holdCheck(8);
    applyStimulus(8'h63, -1, 1'b0);

    // Reset wins over a simultaneous start.
    rst     = 1'b1;
    start2  = 1'b1;
    bcd_in2 = 8'h42;
    @(negedge clk);
    rst    = 1'b0;
    start2 = 1'b0;
    last_bin2 = 0;
    last_err2 = 0;
    checkOutput("rstStartBusy", int'(busy2), 0);
    holdCheck(2);

    for (int n = 0; n < 40; n++) begin
      rnd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) rnd[3:0] = 4'($urandom_range(10, 15));
        else rnd[7:4] = 4'($urandom_range(10, 15));
      end
      applyStimulus(rnd, -1, 1'b1);
      holdCheck($urandom_range(0, 2));
    end

    applyStimulusWide(12'h999);
    applyStimulusWide(12'h100);
    applyStimulusWide(12'h9A9);
    for (int n = 0; n < 6; n++) begin
      applyStimulusWide({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
